// File: rtl/flag_unit_pkg.sv
// flag_unit_pkg
// Shared definitions for the status-flag interface between flag_unit and
// the controller that consumes it.
//   - FLAG_* : 2-bit per-flag update controls
//   - COND_* : 4-bit branch condition selectors
//   - flags_t: packed {z,s,c,v} flag vector
//   - next_flag(): applies one 2-bit control to one flag
package flag_unit_pkg;

  localparam logic [1:0] FLAG_FORCE0 = 2'b00;
  localparam logic [1:0] FLAG_FORCE1 = 2'b01;
  localparam logic [1:0] FLAG_UPDATE = 2'b10;
  localparam logic [1:0] FLAG_KEEP   = 2'b11;

  localparam logic [3:0] COND_Z      = 4'h0;  // Z
  localparam logic [3:0] COND_C      = 4'h1;  // C
  localparam logic [3:0] COND_ZC     = 4'h2;  // Z & C
  localparam logic [3:0] COND_ZNEV   = 4'h3;  // Z != V
  localparam logic [3:0] COND_GT     = 4'h4;  // !Z & (S == V)
  localparam logic [3:0] COND_ALWAYS = 4'h5;  // 1; all higher codes are 0

  typedef struct packed {
    logic z;
    logic s;
    logic c;
    logic v;
  } flags_t;

  function automatic logic next_flag(input logic [1:0] ctrl,
                                     input logic       cur,
                                     input logic       cand);
    logic r;
    case (ctrl)
      FLAG_FORCE0: r = 1'b0;
      FLAG_FORCE1: r = 1'b1;
      FLAG_UPDATE: r = cand;
      default:     r = cur;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/flag_unit_stack.sv
// flag_stack
// LIFO of 4-bit flag vectors used to save/restore flags across call/return.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_push, i_pop     already-qualified push / pop requests
//   i_din             flags to save
//   o_dout            flags at the stack top (valid when not empty)
//   o_full, o_empty   occupancy
//   o_err             sticky misuse flag (overflow, underflow, push+pop)
//   o_pop_ok          a legal pop happens this cycle
module flag_stack #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [3:0] i_din,
  output logic [3:0] o_dout,
  output logic       o_full,
  output logic       o_empty,
  output logic       o_err,
  output logic       o_pop_ok
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  // Pointer counts 0..DEPTH without wrapping, so it needs one extra bit.
  logic [PW-1:0] r_ptr;
  logic [3:0]    r_mem [DEPTH];
  logic          r_err;

  logic          w_push_ok;
  logic          w_misuse;
  logic [IW-1:0] w_top_idx;

  assign o_full    = (r_ptr == PW'(DEPTH));
  assign o_empty   = (r_ptr == '0);
  assign w_push_ok = i_push & ~i_pop & ~o_full;
  assign o_pop_ok  = i_pop & ~i_push & ~o_empty;
  assign w_misuse  = (i_push & i_pop) | (i_push & o_full) | (i_pop & o_empty);

  // Top entry sits at ptr-1; DEPTH is a power of two so ptr==DEPTH maps
  // onto the last slot through the truncated low bits.
  assign w_top_idx = r_ptr[IW-1:0] - IW'(1);
  assign o_dout    = r_mem[w_top_idx];
  assign o_err     = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_push_ok)     r_ptr <= r_ptr + PW'(1);
      else if (o_pop_ok) r_ptr <= r_ptr - PW'(1);
      if (w_misuse)      r_err <= 1'b1;
    end
  end

  // Contents need no reset; only the pointer defines what is valid.
  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) r_mem[r_ptr[IW-1:0]] <= i_din;
  end

endmodule

// File: rtl/flag_unit.sv
// flag_unit
// Status-flag register (Z,S,C,V), branch-condition evaluator, flag
// save/restore stack and single-step halt latch.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   instr_valid                    qualifies every update
//   zf/sf/cf/of_ctrl               per-flag 2-bit update control
//   alu_result/carry/overflow      candidate flag sources
//   cond_code -> cond_taken        combinational condition decode
//   flag_push, flag_pop            save / restore flags
//   halt_req, resume               halt latch controls
//   zero/sign/carry/overflow_flag  registered flags
//   stack_empty/full/err, halted   status
module flag_unit
  import flag_unit_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [1:0]        zf_ctrl,
  input  logic [1:0]        sf_ctrl,
  input  logic [1:0]        cf_ctrl,
  input  logic [1:0]        of_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  input  logic [3:0]        cond_code,
  input  logic              flag_push,
  input  logic              flag_pop,
  input  logic              halt_req,
  input  logic              resume,
  output logic              zero_flag,
  output logic              sign_flag,
  output logic              carry_flag,
  output logic              overflow_flag,
  output logic              cond_taken,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              stack_err,
  output logic              halted
);

  flags_t     r_flags;
  logic       r_halted;

  logic       w_en;
  flags_t     w_upd;
  flags_t     w_next;
  logic [3:0] w_stack_dout;
  logic       w_pop_ok;

  // Halted suppresses everything an instruction would do.
  assign w_en = instr_valid & ~r_halted;

  flag_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .clk      (clk),
    .rst      (rst),
    .i_push   (w_en & flag_push),
    .i_pop    (w_en & flag_pop),
    .i_din    (r_flags),
    .o_dout   (w_stack_dout),
    .o_full   (stack_full),
    .o_empty  (stack_empty),
    .o_err    (stack_err),
    .o_pop_ok (w_pop_ok)
  );

  always_comb begin
    w_upd   = r_flags;
    w_upd.z = next_flag(zf_ctrl, r_flags.z, (alu_result == '0));
    w_upd.s = next_flag(sf_ctrl, r_flags.s, alu_result[DATA_W-1]);
    w_upd.c = next_flag(cf_ctrl, r_flags.c, alu_carry);
    w_upd.v = next_flag(of_ctrl, r_flags.v, alu_overflow);
  end

  // A legal pop overrides all ctrl fields; a failed pop falls back to ctrl.
  assign w_next = w_pop_ok ? flags_t'(w_stack_dout) : w_upd;

  always_ff @(posedge clk) begin
    if (rst)       r_flags <= '0;
    else if (w_en) r_flags <= w_next;
  end

  // halt_req held alongside resume keeps the unit halted.
  always_ff @(posedge clk) begin
    if (rst)                             r_halted <= 1'b0;
    else if (r_halted)                   r_halted <= ~(resume & ~halt_req);
    else if (instr_valid && halt_req)    r_halted <= 1'b1;
  end

  always_comb begin
    cond_taken = 1'b0;
    case (cond_code)
      COND_Z:      cond_taken = r_flags.z;
      COND_C:      cond_taken = r_flags.c;
      COND_ZC:     cond_taken = r_flags.z & r_flags.c;
      COND_ZNEV:   cond_taken = r_flags.z ^ r_flags.v;
      COND_GT:     cond_taken = ~r_flags.z & ~(r_flags.s ^ r_flags.v);
      COND_ALWAYS: cond_taken = 1'b1;
      default:     cond_taken = 1'b0;
    endcase
  end

  assign zero_flag     = r_flags.z;
  assign sign_flag     = r_flags.s;
  assign carry_flag    = r_flags.c;
  assign overflow_flag = r_flags.v;
  assign halted        = r_halted;

endmodule

// File: tb/tb_flag_unit.sv
module tb_flag_unit;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              instr_valid;
  logic [1:0]        zf_ctrl, sf_ctrl, cf_ctrl, of_ctrl;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry, alu_overflow;
  logic [3:0]        cond_code;
  logic              flag_push, flag_pop, halt_req, resume;
  logic              zero_flag, sign_flag, carry_flag, overflow_flag;
  logic              cond_taken, stack_empty, stack_full, stack_err, halted;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: flags as {Z,S,C,V}, stack as a queue (back = top).
  logic [3:0] m_flags;
  logic [3:0] m_stack[$];
  logic       m_err;
  logic       m_halted;

  flag_unit #(.DATA_W(DATA_W), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid),
    .zf_ctrl(zf_ctrl), .sf_ctrl(sf_ctrl), .cf_ctrl(cf_ctrl), .of_ctrl(of_ctrl),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .cond_code(cond_code), .flag_push(flag_push), .flag_pop(flag_pop),
    .halt_req(halt_req), .resume(resume),
    .zero_flag(zero_flag), .sign_flag(sign_flag), .carry_flag(carry_flag),
    .overflow_flag(overflow_flag), .cond_taken(cond_taken),
    .stack_empty(stack_empty), .stack_full(stack_full), .stack_err(stack_err),
    .halted(halted)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic model_cond(input logic [3:0] f, input logic [3:0] cc);
    logic z, s, c, v;
    {z, s, c, v} = f;
    case (cc)
      4'd0: return z;
      4'd1: return c;
      4'd2: return z && c;
      4'd3: return z != v;
      4'd4: return !z && (s == v);
      4'd5: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic pick(input logic [1:0] ctrl, input logic cur, input logic cand);
    if (ctrl == 2'd0) return 1'b0;
    if (ctrl == 2'd1) return 1'b1;
    if (ctrl == 2'd2) return cand;
    return cur;
  endfunction

  task automatic model_step();
    logic [3:0] upd;
    if (rst) begin
      m_flags = 4'h0; m_stack.delete(); m_err = 1'b0; m_halted = 1'b0;
      return;
    end
    if (instr_valid && !m_halted) begin
      upd = {pick(zf_ctrl, m_flags[3], alu_result == 0),
             pick(sf_ctrl, m_flags[2], alu_result[DATA_W-1]),
             pick(cf_ctrl, m_flags[1], alu_carry),
             pick(of_ctrl, m_flags[0], alu_overflow)};
      if (flag_push && flag_pop) begin
        m_err = 1'b1; m_flags = upd;
      end else if (flag_push) begin
        if (m_stack.size() == DEPTH) m_err = 1'b1;
        else m_stack.push_back(m_flags);
        m_flags = upd;
      end else if (flag_pop) begin
        if (m_stack.size() == 0) begin m_err = 1'b1; m_flags = upd; end
        else m_flags = m_stack.pop_back();
      end else begin
        m_flags = upd;
      end
      if (halt_req) m_halted = 1'b1;
    end else if (m_halted && resume && !halt_req) begin
      m_halted = 1'b0;
    end
  endtask

  // ---------------- driver ----------------
  task automatic idle();
    rst = 1'b0; instr_valid = 1'b0;
    zf_ctrl = 2'd3; sf_ctrl = 2'd3; cf_ctrl = 2'd3; of_ctrl = 2'd3;
    alu_result = '0; alu_carry = 1'b0; alu_overflow = 1'b0;
    cond_code = 4'd0; flag_push = 1'b0; flag_pop = 1'b0;
    halt_req = 1'b0; resume = 1'b0;
  endtask

  task automatic set_ctrl(input logic [7:0] c);
    {zf_ctrl, sf_ctrl, cf_ctrl, of_ctrl} = c;
  endtask

  // Inputs are already driven; check the combinational condition, clock
  // once, advance the model and compare every registered output.
  task automatic tick();
    #2;
    check("cond_taken", cond_taken, model_cond(m_flags, cond_code));
    @(posedge clk);
    model_step();
    #1;
    check("flags", {zero_flag, sign_flag, carry_flag, overflow_flag}, m_flags);
    check("halted", halted, m_halted);
    check("stack_empty", stack_empty, m_stack.size() == 0);
    check("stack_full", stack_full, m_stack.size() == DEPTH);
    check("stack_err", stack_err, m_err);
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; tick(); rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_flags = 4'h0; m_err = 1'b0; m_halted = 1'b0;
    idle();
    @(posedge clk); #1;

    // Reset state
    do_reset();
    check("rst_flags", {zero_flag, sign_flag, carry_flag, overflow_flag}, 4'h0);
    check("rst_empty", stack_empty, 1'b1);

    // Update from ALU: zero result, carry in
    idle(); instr_valid = 1'b1; set_ctrl(8'hAA);
    alu_result = 8'h00; alu_carry = 1'b1; alu_overflow = 1'b0;
    tick();
    check("alu_update", {zero_flag, sign_flag, carry_flag, overflow_flag}, 4'b1010);

    // Z=1, V=0, then walk condition codes
    idle(); instr_valid = 1'b1; set_ctrl(8'b01_11_11_00); tick();
    idle(); cond_code = 4'd3; #2; check("cond_znev", cond_taken, 1'b1); tick();
    idle(); cond_code = 4'd4; #2; check("cond_gt", cond_taken, 1'b0); tick();
    idle(); cond_code = 4'd5; #2; check("cond_always", cond_taken, 1'b1); tick();
    idle(); cond_code = 4'd7; #2; check("cond_7", cond_taken, 1'b0); tick();

    // Flags 1010, push, clear, pop
    do_reset();
    idle(); instr_valid = 1'b1; set_ctrl(8'b01_00_01_00); tick();
    idle(); instr_valid = 1'b1; flag_push = 1'b1; tick();
    idle(); instr_valid = 1'b1; set_ctrl(8'h00); tick();
    check("cleared", {zero_flag, sign_flag, carry_flag, overflow_flag}, 4'h0);
    idle(); instr_valid = 1'b1; flag_pop = 1'b1; set_ctrl(8'h55); tick();
    check("restored", {zero_flag, sign_flag, carry_flag, overflow_flag}, 4'b1010);
    check("restored_empty", stack_empty, 1'b1);
    check("restored_err", stack_err, 1'b0);

    // Overflow then underflow
    for (int i = 0; i < 5; i++) begin
      idle(); instr_valid = 1'b1; flag_push = 1'b1; set_ctrl(8'h55); tick();
      if (i == 3) check("full_after_4", stack_full, 1'b1);
      if (i == 3) check("no_err_after_4", stack_err, 1'b0);
    end
    check("err_after_5", stack_err, 1'b1);
    for (int i = 0; i < 5; i++) begin
      idle(); instr_valid = 1'b1; flag_pop = 1'b1; tick();
    end
    check("err_sticky", stack_err, 1'b1);

    // Halt / resume
    do_reset();
    idle(); instr_valid = 1'b1; halt_req = 1'b1; set_ctrl(8'h55); tick();
    check("halt_flags", {zero_flag, sign_flag, carry_flag, overflow_flag}, 4'hF);
    check("halt_set", halted, 1'b1);
    idle(); instr_valid = 1'b1; set_ctrl(8'h00); tick();
    check("halt_hold", {zero_flag, sign_flag, carry_flag, overflow_flag}, 4'hF);
    idle(); resume = 1'b1; halt_req = 1'b1; tick();
    check("resume_blocked", halted, 1'b1);
    idle(); resume = 1'b1; tick();
    check("resumed", halted, 1'b0);
    idle(); instr_valid = 1'b1; set_ctrl(8'h00); tick();
    check("post_resume", {zero_flag, sign_flag, carry_flag, overflow_flag}, 4'h0);

    // Reset while halted with entries stacked
    for (int i = 0; i < 3; i++) begin
      idle(); instr_valid = 1'b1; flag_push = 1'b1; set_ctrl(8'h55); tick();
    end
    idle(); instr_valid = 1'b1; halt_req = 1'b1; flag_push = 1'b1; flag_pop = 1'b1; tick();
    idle(); rst = 1'b1; instr_valid = 1'b1; flag_push = 1'b1; tick();
    check("rst_halt", halted, 1'b0);
    check("rst_stack", stack_empty, 1'b1);
    check("rst_err", stack_err, 1'b0);
    check("rst_flags2", {zero_flag, sign_flag, carry_flag, overflow_flag}, 4'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      idle();
      rst          = ($urandom_range(0, 79) == 0);
      instr_valid  = ($urandom_range(0, 3) != 0);
      set_ctrl(8'($urandom));
      alu_result   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      alu_carry    = 1'($urandom);
      alu_overflow = 1'($urandom);
      cond_code    = 4'($urandom);
      flag_push    = ($urandom_range(0, 3) == 0);
      flag_pop     = ($urandom_range(0, 3) == 0);
      halt_req     = ($urandom_range(0, 19) == 0);
      resume       = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
